// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC operand serializer.
// The ERR state exists only when ECC_OPERAND_CHECK_EN is defined.
package ecc_pkg;

    localparam int WORD_W       = 32;
    localparam int NIBBLE_W     = 4;
    localparam int NUM_NIBBLES  = 8;
    localparam int FRAME_CYCLES = 9;
    localparam int IDX_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HEAD      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DRAIN     = 3'd4
`ifdef ECC_OPERAND_CHECK_EN
        , ST_ERR     = 3'd5
`endif
    } state_e;

`ifdef ECC_OPERAND_CHECK_EN
    // Prime must be at least 2 and every coordinate-like operand must be reduced mod prime.
    function automatic logic operands_ok(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] prime,
        input logic [WORD_W-1:0] px,
        input logic [WORD_W-1:0] py
    );
        return (prime >= 32'd2) && (a < prime) && (px < prime) && (py < prime);
    endfunction
`endif

endpackage

// File: rtl/ecc_nibble_shift.sv
// One operand lane: holds the accepted 32-bit word and presents the
// selected nibble on a registered output, zero whenever not shifting.
module ecc_nibble_shift
    import ecc_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [WORD_W-1:0]   i_word,
    input  logic                i_sel_en,
    input  logic [IDX_W-1:0]    i_idx,
    output logic [NIBBLE_W-1:0] o_nib
);

    logic [WORD_W-1:0]   word_q, word_d;
    logic [NIBBLE_W-1:0] nib_q, nib_d;

    // Next word and next nibble; the select uses the upcoming index so the output lines up with the FSM.
    always_comb begin
        word_d = word_q;
        nib_d  = {NIBBLE_W{1'b0}};
        if (i_load) begin
            word_d = i_word;
        end else begin
            word_d = word_q;
        end
        if (i_sel_en) begin
            nib_d = word_q[{i_idx, 2'b00} +: NIBBLE_W];
        end else begin
            nib_d = {NIBBLE_W{1'b0}};
        end
    end

    // Lane registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_q <= {WORD_W{1'b0}};
            nib_q  <= {NIBBLE_W{1'b0}};
        end else begin
            word_q <= word_d;
            nib_q  <= nib_d;
        end
    end

    assign o_nib = nib_q;

endmodule

// File: rtl/ecc_operand_serializer.sv
// Job feeder for the ECC scalar-multiplier core: HEAD strobe, 8 nibble cycles,
// then busy until core_done plus readout drain. Optional check: ECC_OPERAND_CHECK_EN.
module ecc_operand_serializer
    import ecc_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 10,
    parameter int unsigned WAIT_TIMEOUT = 4096
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_a,
    input  logic [WORD_W-1:0]   in_prime,
    input  logic [WORD_W-1:0]   in_px,
    input  logic [WORD_W-1:0]   in_py,
    input  logic [WORD_W-1:0]   in_k,
    output logic                o_start,
    output logic [NIBBLE_W-1:0] o_a,
    output logic [NIBBLE_W-1:0] o_prime,
    output logic [NIBBLE_W-1:0] o_px,
    output logic [NIBBLE_W-1:0] o_py,
    output logic [NIBBLE_W-1:0] o_k,
    input  logic                core_done,
    output logic                o_busy,
    output logic                o_timeout,
    output logic                o_err
);

    localparam int CNT_W = 32;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             timeout_q, timeout_d;
    logic             load_s;
    logic             sel_en_s;

    // Next-state, counters and registered-output precompute.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        tmo_d     = tmo_q;
        timeout_d = 1'b0;
        load_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d   = {IDX_W{1'b0}};
                drain_d = {CNT_W{1'b0}};
                tmo_d   = {CNT_W{1'b0}};
                if (in_valid) begin
                    load_s = 1'b1;
`ifdef ECC_OPERAND_CHECK_EN
                    if (operands_ok(in_a, in_prime, in_px, in_py)) begin
                        state_d = ST_HEAD;
                    end else begin
                        state_d = ST_ERR;
                    end
`else
                    state_d = ST_HEAD;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEAD: begin
                state_d = ST_SHIFT;
                idx_d   = {IDX_W{1'b0}};
            end
            ST_SHIFT: begin
                if (idx_q == IDX_W'(NUM_NIBBLES - 1)) begin
                    state_d = ST_WAIT_DONE;
                    tmo_d   = {CNT_W{1'b0}};
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (core_done) begin
                    state_d = ST_DRAIN;
                    drain_d = CNT_W'(DRAIN_CYCLES - 32'd1);
                end else if ((WAIT_TIMEOUT != 32'd0) && (tmo_q == CNT_W'(WAIT_TIMEOUT - 32'd1))) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else if (WAIT_TIMEOUT != 32'd0) begin
                    tmo_d = tmo_q + 32'd1;
                end else begin
                    tmo_d = tmo_q;
                end
            end
            ST_DRAIN: begin
                if (drain_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - 32'd1;
                end
            end
`ifdef ECC_OPERAND_CHECK_EN
            ST_ERR: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        start_d  = (state_d == ST_HEAD);
        busy_d   = (state_d != ST_IDLE);
        ready_d  = (state_d == ST_IDLE);
        sel_en_s = (state_d == ST_SHIFT);
    end

    // Control and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= {IDX_W{1'b0}};
            drain_q   <= {CNT_W{1'b0}};
            tmo_q     <= {CNT_W{1'b0}};
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            tmo_q     <= tmo_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ECC_OPERAND_CHECK_EN
    logic err_q, err_d;

    // Error pulse is high for the single cycle spent in ERR.
    always_comb begin
        err_d = (state_d == ST_ERR);
    end

    // Error pulse register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign in_ready  = ready_q;
    assign o_start   = start_q;
    assign o_busy    = busy_q;
    assign o_timeout = timeout_q;

    ecc_nibble_shift u_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(load_s), .i_word(in_a),
        .i_sel_en(sel_en_s), .i_idx(idx_d), .o_nib(o_a)
    );
    ecc_nibble_shift u_prime (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(load_s), .i_word(in_prime),
        .i_sel_en(sel_en_s), .i_idx(idx_d), .o_nib(o_prime)
    );
    ecc_nibble_shift u_px (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(load_s), .i_word(in_px),
        .i_sel_en(sel_en_s), .i_idx(idx_d), .o_nib(o_px)
    );
    ecc_nibble_shift u_py (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(load_s), .i_word(in_py),
        .i_sel_en(sel_en_s), .i_idx(idx_d), .o_nib(o_py)
    );
    ecc_nibble_shift u_k (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(load_s), .i_word(in_k),
        .i_sel_en(sel_en_s), .i_idx(idx_d), .o_nib(o_k)
    );

endmodule
